ac_instr_scheduler: RTL and testbench

- Shares the single accumulator controller between two instruction requesters, R0 and R1.
- Each requester has its own DEPTH-entry instruction/operand FIFO.
- A round-robin arbiter picks the next instruction; an issue FSM runs the controller's ready/new_instruction handshake and returns a per-requester completion pulse.
- Sits between the host-side instruction sources and the accumulator controller/datapath.

---
 rtl/ac_instr_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ac_instr_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_instr_scheduler.sv
// rtl/ac_instr_scheduler.sv - two-requester round-robin instruction scheduler for the accumulator controller
module ac_instr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic [2:0]       r0_instr,
  input  logic [WIDTH-1:0] r0_operand,
  output logic             r0_accept,
  output logic             r0_done,
  output logic             r0_err,
  input  logic             r1_valid,
  input  logic [2:0]       r1_instr,
  input  logic [WIDTH-1:0] r1_operand,
  output logic             r1_accept,
  output logic             r1_done,
  output logic             r1_err,
  input  logic             ctl_ready,
  output logic             ctl_new_instruction,
  output logic [2:0]       ctl_instruction,
  output logic [WIDTH-1:0] ctl_operand,
  output logic             busy,
  output logic             grant_id
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = WIDTH + 3;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_CNT    = TW'(TIMEOUT);
  localparam logic [2:0]    OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;

  logic [EW-1:0] mem   [2][DEPTH];
  logic [PW-1:0] wptr  [2];
  logic [PW-1:0] rptr  [2];
  logic [CW-1:0] count [2];
  logic [EW-1:0] din   [2];
  logic [1:0]    valid, full, empty, push, pop;

  logic          grant_valid, grant_sel, last_grant;
  logic [EW-1:0] head;
  logic [2:0]    head_instr;
  logic [WIDTH-1:0] head_operand;
  logic [TW-1:0] tcnt, tcnt_next;

  assign valid  = {r1_valid, r0_valid};
  assign din[0] = {r0_instr, r0_operand};
  assign din[1] = {r1_instr, r1_operand};
  assign full   = {count[1] == FULL_CNT, count[0] == FULL_CNT};
  assign empty  = {count[1] == '0, count[0] == '0};
  assign push   = valid & ~full;
  assign pop    = grant_valid ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;

  assign r0_accept = !full[0];
  assign r1_accept = !full[1];

  // With both FIFOs occupied the requester that did not win last time goes next.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (state == IDLE && ctl_ready && empty != 2'b11) begin
      grant_valid = 1'b1;
      if (empty == 2'b00) grant_sel = !last_grant;
      else                grant_sel = empty[0];
    end
  end

  assign head         = mem[grant_sel][rptr[grant_sel]];
  assign head_instr   = head[EW-1:WIDTH];
  assign head_operand = head[WIDTH-1:0];
  assign tcnt_next    = tcnt + 1'b1;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wptr[i]] <= din[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      last_grant          <= 1'b1;
      tcnt                <= '0;
      ctl_new_instruction <= 1'b0;
      ctl_instruction     <= '0;
      ctl_operand         <= '0;
      busy                <= 1'b0;
      grant_id            <= 1'b0;
      r0_done             <= 1'b0;
      r0_err              <= 1'b0;
      r1_done             <= 1'b0;
      r1_err              <= 1'b0;
    end else begin
      r0_done <= 1'b0;
      r0_err  <= 1'b0;
      r1_done <= 1'b0;
      r1_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_sel;
            if (head_instr == OP_ILLEGAL) begin
              r0_done <= !grant_sel;
              r0_err  <= !grant_sel;
              r1_done <= grant_sel;
              r1_err  <= grant_sel;
            end else begin
              ctl_instruction     <= head_instr;
              ctl_operand         <= head_operand;
              ctl_new_instruction <= 1'b1;
              busy                <= 1'b1;
              grant_id            <= grant_sel;
              tcnt                <= '0;
              state               <= ISSUE;
            end
          end
        end
        ISSUE, WAIT: begin
          tcnt <= tcnt_next;
          // Timeout is checked first so it wins over a completion in the same cycle.
          if (tcnt_next == TMO_CNT) begin
            r0_done             <= !grant_id;
            r0_err              <= !grant_id;
            r1_done             <= grant_id;
            r1_err              <= grant_id;
            ctl_new_instruction <= 1'b0;
            busy                <= 1'b0;
            state               <= IDLE;
          end else if (state == ISSUE) begin
            if (!ctl_ready) begin
              ctl_new_instruction <= 1'b0;
              state               <= WAIT;
            end
          end else if (ctl_ready) begin
            r0_done <= !grant_id;
            r1_done <= grant_id;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ac_instr_scheduler.sv
// tb/tb_ac_instr_scheduler.sv - self-checking bench for ac_instr_scheduler
module tb_ac_instr_scheduler;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 15;
  localparam int M_NORMAL = 0;
  localparam int M_STALL  = 1;
  localparam int M_STUCK  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic [2:0] r0_instr = '0, r1_instr = '0;
  logic [7:0] r0_operand = '0, r1_operand = '0;
  logic       r0_accept, r0_done, r0_err, r1_accept, r1_done, r1_err;
  logic       ctl_ready, ctl_new_instruction, busy, grant_id;
  logic [2:0] ctl_instruction;
  logic [7:0] ctl_operand;

  int mode = M_NORMAL;
  int checks = 0;
  int errors = 0;
  int push_count = 0;
  bit chk_en = 1'b0;

  ac_instr_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_instr(r0_instr), .r0_operand(r0_operand),
    .r0_accept(r0_accept), .r0_done(r0_done), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_instr(r1_instr), .r1_operand(r1_operand),
    .r1_accept(r1_accept), .r1_done(r1_done), .r1_err(r1_err),
    .ctl_ready(ctl_ready), .ctl_new_instruction(ctl_new_instruction),
    .ctl_instruction(ctl_instruction), .ctl_operand(ctl_operand),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Controller: drops ready one edge after seeing an issue, executes 1 cycle (2 for multiply).
  logic rdy_q;
  int   exec_left;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q     <= 1'b1;
      exec_left <= 0;
    end else if (rdy_q && ctl_new_instruction) begin
      rdy_q     <= 1'b0;
      exec_left <= (ctl_instruction == 3'b110) ? 2 : 1;
    end else if (!rdy_q) begin
      if (exec_left <= 1) rdy_q <= 1'b1;
      exec_left <= exec_left - 1;
    end
  end
  assign ctl_ready = (mode == M_STALL) ? 1'b0 : (mode == M_STUCK) ? 1'b1 : rdy_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: FIFO queues, round-robin pick, fixed per-kind latency table.
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int   cyc, m_g, m_dn, m_req;
  bit   m_active, m_ill, m_stuck, m_last;
  logic e_busy, e_new, e_gid;
  logic [2:0] e_instr;
  logic [7:0] e_oper;
  logic [1:0] e_done, e_err, e_acc;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_active = 1'b0;
    m_last   = 1'b1;
    e_busy = 1'b0; e_new = 1'b0; e_gid = 1'b0;
    e_instr = '0; e_oper = '0;
    e_done = '0; e_err = '0; e_acc = 2'b11;
  endtask

  task automatic model_step();
    int sz0, sz1, sel, n;
    logic [10:0] head;
    cyc++;
    sz0 = q0.size();
    sz1 = q1.size();
    if (m_active && cyc > m_g + m_dn) m_active = 1'b0;
    if (!m_active && mode != M_STALL && (sz0 > 0 || sz1 > 0)) begin
      if (sz0 > 0 && sz1 > 0) sel = m_last ? 0 : 1;
      else                    sel = (sz0 > 0) ? 0 : 1;
      m_last = (sel == 1);
      if (sel == 1) head = q1.pop_front();
      else          head = q0.pop_front();
      m_active = 1'b1;
      m_g      = cyc;
      m_req    = sel;
      m_ill    = (head[10:8] == 3'b111);
      m_stuck  = (mode == M_STUCK);
      if (m_ill)                    m_dn = 0;
      else if (m_stuck)             m_dn = TIMEOUT;
      else if (head[10:8] == 3'b110) m_dn = 4;
      else                          m_dn = 3;
      if (!m_ill) begin
        e_instr = head[10:8];
        e_oper  = head[7:0];
        e_gid   = (sel == 1);
      end
    end
    if (r0_valid && sz0 < DEPTH) q0.push_back({r0_instr, r0_operand});
    if (r1_valid && sz1 < DEPTH) q1.push_back({r1_instr, r1_operand});
    e_busy = 1'b0; e_new = 1'b0; e_done = '0; e_err = '0;
    if (m_active) begin
      n = cyc - m_g;
      if (m_ill) begin
        e_done[m_req] = (n == 0);
        e_err[m_req]  = (n == 0);
      end else begin
        e_busy = (n < m_dn);
        e_new  = m_stuck ? (n < m_dn) : (n < 2);
        e_done[m_req] = (n == m_dn);
        e_err[m_req]  = (n == m_dn) && m_stuck;
      end
    end
    e_acc = {q1.size() < DEPTH, q0.size() < DEPTH};
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("r0_accept", int'(r0_accept), int'(e_acc[0]));
        chk("r1_accept", int'(r1_accept), int'(e_acc[1]));
        chk("busy", int'(busy), int'(e_busy));
        chk("ctl_new_instruction", int'(ctl_new_instruction), int'(e_new));
        chk("ctl_instruction", int'(ctl_instruction), int'(e_instr));
        chk("ctl_operand", int'(ctl_operand), int'(e_oper));
        if (e_busy) chk("grant_id", int'(grant_id), int'(e_gid));
        chk("r0_done", int'(r0_done), int'(e_done[0]));
        chk("r0_err", int'(r0_err), int'(e_err[0]));
        chk("r1_done", int'(r1_done), int'(e_done[1]));
        chk("r1_err", int'(r1_err), int'(e_err[1]));
      end
    end
  end

  task automatic push(input int r, input logic [2:0] ins, input logic [7:0] op);
    bit ok;
    ok = 1'b0;
    if (r == 0) begin r0_valid = 1'b1; r0_instr = ins; r0_operand = op; end
    else        begin r1_valid = 1'b1; r1_instr = ins; r1_operand = op; end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((r == 0) ? r0_accept : r1_accept) begin
        ok = 1'b1;
        break;
      end
    end
    chk("push_accepted", int'(ok), 1);
    @(posedge clk);
    #2;
    push_count++;
    if (r == 0) r0_valid = 1'b0;
    else        r1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    mode = M_NORMAL;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic observe(input int r, input int ncyc, output int first_done, output int new_cnt,
                         output int busy_cnt, output int err_seen, output int done_cnt,
                         output int gid, output int op);
    first_done = 0; new_cnt = 0; busy_cnt = 0; err_seen = 0; done_cnt = 0; gid = -1; op = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (ctl_new_instruction) new_cnt++;
      if (busy) begin
        busy_cnt++;
        if (gid < 0) gid = int'(grant_id);
      end
      if ((r == 0) ? r0_done : r1_done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        err_seen = int'((r == 0) ? r0_err : r1_err);
        op = int'(ctl_operand);
      end
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fd, nn, bc, es, dc, gid, op, nd;
    logic [5:0] order;
    bit coinc, found;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_new_instruction", int'(ctl_new_instruction), 0);
    chk("reset_accepts", int'({r1_accept, r0_accept}), 3);
    chk("reset_done", int'({r1_done, r0_done}), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // single legal op: issue held 2 cycles, done in 4th cycle after grant
    push(0, 3'b010, 8'h5A);
    observe(0, 12, fd, nn, bc, es, dc, gid, op);
    chk("t1_done_cycle", fd, 5);
    chk("t1_new_cycles", nn, 2);
    chk("t1_busy_cycles", bc, 3);
    chk("t1_done_count", dc, 1);
    chk("t1_err", es, 0);
    chk("t1_operand_at_done", op, 'h5A);

    // alternating service of two full streams
    do_reset();
    fork
      begin
        push(0, 3'b000, 8'h01); push(0, 3'b001, 8'h02); push(0, 3'b011, 8'h03);
      end
      begin
        push(1, 3'b100, 8'h11); push(1, 3'b101, 8'h12); push(1, 3'b011, 8'h13);
      end
    join
    nd = 0; order = '0; coinc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (r0_done && r1_done) coinc = 1'b1;
      if (r1_done && nd < 6) order[nd] = 1'b1;
      if (r0_done || r1_done) nd++;
    end
    chk("t2_done_count", nd, 6);
    chk("t2_order", int'(order), 'b101010);
    chk("t2_coincident", int'(coinc), 0);
    @(posedge clk);
    #2;

    // multiply from R1
    do_reset();
    push(1, 3'b110, 8'h77);
    observe(1, 12, fd, nn, bc, es, dc, gid, op);
    chk("t3_done_cycle", fd, 6);
    chk("t3_busy_cycles", bc, 4);
    chk("t3_grant_id", gid, 1);
    chk("t3_err", es, 0);

    // stalled controller: FIFO fills, fifth push waits, order survives wrap
    do_reset();
    mode = M_STALL;
    push_count = 0;
    fork
      begin
        push(0, 3'b000, 8'h11); push(0, 3'b001, 8'h22); push(0, 3'b010, 8'h33);
        push(0, 3'b011, 8'h44); push(0, 3'b100, 8'h55);
      end
      begin
        for (int k = 0; k < 50 && push_count < 4; k++) @(posedge clk);
        @(negedge clk);
        chk("t4_pushes_before_full", push_count, 4);
        chk("t4_accept_full", int'(r0_accept), 0);
        repeat (4) @(posedge clk);
        #2;
        mode = M_NORMAL;
      end
    join
    observe(0, 40, fd, nn, bc, es, dc, gid, op);
    chk("t4_last_operand", int'(ctl_operand), 'h55);
    chk("t4_last_instr", int'(ctl_instruction), 4);

    // illegal opcode: no issue, done+err the cycle after grant
    do_reset();
    push(0, 3'b111, 8'h00);
    observe(0, 8, fd, nn, bc, es, dc, gid, op);
    chk("t5_illegal_done_cycle", fd, 2);
    chk("t5_illegal_err", es, 1);
    chk("t5_illegal_no_issue", nn, 0);
    chk("t5_illegal_no_busy", bc, 0);

    // controller never drops ready: timeout
    mode = M_STUCK;
    push(0, 3'b001, 8'h3C);
    observe(0, 25, fd, nn, bc, es, dc, gid, op);
    chk("t5_timeout_done_cycle", fd, 17);
    chk("t5_timeout_err", es, 1);
    chk("t5_timeout_busy_cycles", bc, 15);
    chk("t5_timeout_new_cycles", nn, 15);
    mode = M_NORMAL;

    // reset while waiting on the controller
    do_reset();
    push(0, 3'b010, 8'hA5);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy && !ctl_new_instruction) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reached_wait", int'(found), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_busy_cleared", int'(busy), 0);
    chk("t6_new_cleared", int'(ctl_new_instruction), 0);
    chk("t6_accepts", int'({r1_accept, r0_accept}), 3);
    chk("t6_no_done", int'({r1_done, r0_done}), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    fork
      push(1, 3'b001, 8'h21);
      push(0, 3'b001, 8'h12);
    join
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_regrant", int'(found), 1);
    chk("t6_first_grant_r0", int'(grant_id), 0);
    chk("t6_first_operand", int'(ctl_operand), 'h12);
    repeat (20) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
